// File: rtl/pc_seq_ctrl_pkg.sv
// Shared definitions for the fetch-PC sequencer: PC-select encodings, FSM states
// and the default reset vector.
package pc_seq_ctrl_pkg;

    localparam int WIDTH_PCSEL = 2;

    localparam logic [WIDTH_PCSEL-1:0] PCSEL_PC4  = 2'd0;
    localparam logic [WIDTH_PCSEL-1:0] PCSEL_JUMP = 2'd1;

    localparam logic [31:0] PCSEQ_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        PCSEQ_BOOT  = 2'd0,
        PCSEQ_FETCH = 2'd1,
        PCSEQ_WAIT  = 2'd2,
        PCSEQ_DROP  = 2'd3
    } pcseq_state_t;

    function automatic logic is_redirect(input logic ex_valid,
                                         input logic [WIDTH_PCSEL-1:0] pcsel);
        return ex_valid && (pcsel == PCSEL_JUMP);
    endfunction

endpackage

// File: rtl/pc_seq_ctrl_if.sv
// Instruction-memory request port between the fetch sequencer (master) and imem (slave).
interface pc_seq_ctrl_if #(
    parameter int XLEN = 32
);
    // Valid/ready: a transfer happens in any cycle with imem_req && imem_ready;
    // once imem_req is high, imem_addr is held stable until that transfer.
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready
    );
endinterface

// File: rtl/pc_seq_ctrl_sat_counter.sv
// Width-parameterised saturating event counter; sticks at all-ones.
module pc_seq_ctrl_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pc_seq_ctrl.sv
// Fetch-PC sequencer: owns the fetch PC, drives the imem request handshake and
// turns EX redirects / load-use hazards into IF/ID and ID/EX stalls and flushes.
module pc_seq_ctrl
    import pc_seq_ctrl_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(PCSEQ_RESET_PC),
    parameter int              CNT_W    = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ex_valid,
    input  logic [WIDTH_PCSEL-1:0] pcsel_ex,
    input  logic [XLEN-1:0]        jump_target_ex,
    input  logic                   load_use_hz,
    pc_seq_ctrl_if.master          imem,
    output logic                   if_valid,
    output logic                   id_stall,
    output logic                   flush_id,
    output logic                   flush_ex,
    output logic [CNT_W-1:0]       redirect_cnt,
    output pcseq_state_t           dbg_state
);

    pcseq_state_t    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pend_pc;
    logic            pend_valid;
    logic            req_q;

    logic            redirect;
    logic            stall;
    logic            xfer;
    logic [XLEN-1:0] target;

    // Gating with rst_n keeps every control output low while reset is held.
    assign redirect = rst_n && is_redirect(ex_valid, pcsel_ex);
    assign stall    = rst_n && load_use_hz && !redirect;
    assign xfer     = req_q && imem.imem_ready;
    assign target   = jump_target_ex & ~XLEN'(1);

    assign if_valid = xfer && !pend_valid && !redirect && !stall;
    assign id_stall = stall;
    assign flush_id = redirect;
    assign flush_ex = redirect || stall;

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc;
    assign dbg_state      = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= PCSEQ_BOOT;
            pc         <= RESET_PC;
            pend_pc    <= RESET_PC;
            pend_valid <= 1'b0;
            req_q      <= 1'b0;
        end else begin
            case (state)
                PCSEQ_BOOT: begin
                    req_q <= 1'b1;
                    state <= PCSEQ_FETCH;
                    if (redirect) begin
                        pc <= target;
                    end
                end

                PCSEQ_FETCH, PCSEQ_WAIT: begin
                    if (xfer) begin
                        state <= PCSEQ_FETCH;
                        if (redirect) begin
                            pc <= target;
                        end else if (!stall) begin
                            pc <= pc + XLEN'(4);
                        end
                    end else if (redirect) begin
                        // Address is locked by the handshake: park the target
                        // and discard the word this request returns.
                        pend_pc    <= target;
                        pend_valid <= 1'b1;
                        state      <= PCSEQ_DROP;
                    end else begin
                        state <= PCSEQ_WAIT;
                    end
                end

                PCSEQ_DROP: begin
                    if (xfer) begin
                        pc         <= redirect ? target : pend_pc;
                        pend_valid <= 1'b0;
                        state      <= PCSEQ_FETCH;
                    end else if (redirect) begin
                        pend_pc <= target;
                    end
                end

                default: begin
                    state <= PCSEQ_BOOT;
                end
            endcase
        end
    end

    pc_seq_ctrl_sat_counter #(
        .W(CNT_W)
    ) u_redirect_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (redirect),
        .count (redirect_cnt)
    );

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Directed bench for pc_seq_ctrl: delivered fetch addresses go through an expected
// queue; control outputs are checked cycle by cycle.
module tb_pc_seq_ctrl;
    import pc_seq_ctrl_pkg::*;

    logic                   clk;
    logic                   rst_n;
    logic                   ex_valid;
    logic [WIDTH_PCSEL-1:0] pcsel_ex;
    logic [31:0]            jump_target_ex;
    logic                   load_use_hz;
    logic                   if_valid;
    logic                   id_stall;
    logic                   flush_id;
    logic                   flush_ex;
    logic [3:0]             redirect_cnt;
    pcseq_state_t           dbg_state;

    logic [31:0] exp_q[$];
    int          errors;
    int          checks;
    int          m_cnt;
    logic [31:0] prev_tgt;
    logic [31:0] tgt;
    logic [31:0] got_addr;

    pc_seq_ctrl_if #(.XLEN(32)) imem ();

    pc_seq_ctrl #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000),
        .CNT_W    (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_valid       (ex_valid),
        .pcsel_ex       (pcsel_ex),
        .jump_target_ex (jump_target_ex),
        .load_use_hz    (load_use_hz),
        .imem           (imem),
        .if_valid       (if_valid),
        .id_stall       (id_stall),
        .flush_id       (flush_id),
        .flush_ex       (flush_ex),
        .redirect_cnt   (redirect_cnt),
        .dbg_state      (dbg_state)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard sample on the falling edge, then advance to just after the rising edge.
    task automatic step();
        @(negedge clk);
        if (rst_n && imem.imem_req && imem.imem_ready && if_valid) begin
            got_addr = imem.imem_addr;
            if (exp_q.size() == 0) begin
                check("sb_unexpected_fetch", {32'h0, got_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                check("sb_fetch_addr", {32'h0, got_addr}, {32'h0, exp_q.pop_front()});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_redirect(input logic [31:0] t);
        ex_valid       = 1'b1;
        pcsel_ex       = PCSEL_JUMP;
        jump_target_ex = t;
    endtask

    task automatic clear_redirect();
        ex_valid = 1'b0;
        pcsel_ex = PCSEL_PC4;
    endtask

    task automatic bump_cnt();
        if (m_cnt < 15) m_cnt++;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        m_cnt  = 0;
        rst_n  = 1'b0;
        jump_target_ex = 32'h0;
        imem.imem_ready = 1'b1;
        // Hazard inputs active during reset must not leak to the outputs.
        drive_redirect(32'h0000_0400);
        load_use_hz = 1'b1;
        #2;
        check("rst_req", imem.imem_req, 0);
        check("rst_addr", imem.imem_addr, 0);
        check("rst_if_valid", if_valid, 0);
        check("rst_stall", id_stall, 0);
        check("rst_flush_id", flush_id, 0);
        check("rst_flush_ex", flush_ex, 0);
        check("rst_cnt", redirect_cnt, 0);
        check("rst_state", dbg_state, PCSEQ_BOOT);
        step();
        step();
        clear_redirect();
        load_use_hz = 1'b0;
        rst_n = 1'b1;
        #1;
        check("boot_state", dbg_state, PCSEQ_BOOT);
        check("boot_req", imem.imem_req, 0);
        step();

        // sequential fetch from reset
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(32'(i * 4));
            check("seq_addr", imem.imem_addr, i * 4);
            check("seq_if_valid", if_valid, 1);
            step();
        end

        // taken branch at 0x10, odd target
        drive_redirect(32'h0000_0101);
        #1;
        check("br_addr", imem.imem_addr, 32'h10);
        check("br_flush_id", flush_id, 1);
        check("br_flush_ex", flush_ex, 1);
        check("br_if_valid", if_valid, 0);
        check("br_stall", id_stall, 0);
        step();
        bump_cnt();
        clear_redirect();
        #1;
        check("br_next_addr", imem.imem_addr, 32'h100);
        check("br_cnt", redirect_cnt, m_cnt);
        exp_q.push_back(32'h100);
        step();

        // jump to 0x20, then redirect while the request is stalled
        drive_redirect(32'h0000_0020);
        step();
        bump_cnt();
        imem.imem_ready = 1'b0;
        drive_redirect(32'h0000_0080);
        #1;
        check("pend_addr0", imem.imem_addr, 32'h20);
        check("pend_flush_id", flush_id, 1);
        check("pend_if_valid", if_valid, 0);
        step();
        bump_cnt();
        clear_redirect();
        #1;
        check("pend_state", dbg_state, PCSEQ_DROP);
        check("pend_addr1", imem.imem_addr, 32'h20);
        step();
        imem.imem_ready = 1'b1;
        #1;
        check("pend_addr2", imem.imem_addr, 32'h20);
        check("pend_drop_if_valid", if_valid, 0);
        step();
        check("pend_next_addr", imem.imem_addr, 32'h80);
        check("pend_next_state", dbg_state, PCSEQ_FETCH);
        check("pend_cnt", redirect_cnt, m_cnt);
        exp_q.push_back(32'h80);
        step();

        // jump to 0x40, then a one-cycle load-use stall
        drive_redirect(32'h0000_0040);
        step();
        bump_cnt();
        clear_redirect();
        load_use_hz = 1'b1;
        #1;
        check("lu_addr", imem.imem_addr, 32'h40);
        check("lu_stall", id_stall, 1);
        check("lu_flush_ex", flush_ex, 1);
        check("lu_flush_id", flush_id, 0);
        check("lu_if_valid", if_valid, 0);
        step();
        load_use_hz = 1'b0;
        #1;
        check("lu_repeat_addr", imem.imem_addr, 32'h40);
        exp_q.push_back(32'h40);
        step();
        check("lu_next_addr", imem.imem_addr, 32'h44);
        exp_q.push_back(32'h44);
        step();

        // load-use and redirect together at 0x48: redirect wins
        load_use_hz = 1'b1;
        drive_redirect(32'h0000_0201);
        #1;
        check("both_stall", id_stall, 0);
        check("both_flush_id", flush_id, 1);
        check("both_flush_ex", flush_ex, 1);
        check("both_if_valid", if_valid, 0);
        step();
        bump_cnt();
        clear_redirect();
        load_use_hz = 1'b0;
        #1;
        check("both_next_addr", imem.imem_addr, 32'h200);
        check("both_cnt", redirect_cnt, m_cnt);
        exp_q.push_back(32'h200);
        step();

        // PC wrap at the top of the address space
        drive_redirect(32'hFFFF_FFFD);
        step();
        bump_cnt();
        clear_redirect();
        #1;
        check("wrap_addr0", imem.imem_addr, 32'hFFFF_FFFC);
        exp_q.push_back(32'hFFFF_FFFC);
        step();
        check("wrap_addr1", imem.imem_addr, 32'h0);
        exp_q.push_back(32'h0);
        step();

        // plain wait-state without redirect
        imem.imem_ready = 1'b0;
        #1;
        check("wait_if_valid0", if_valid, 0);
        step();
        check("wait_state", dbg_state, PCSEQ_WAIT);
        check("wait_addr", imem.imem_addr, 32'h4);
        imem.imem_ready = 1'b1;
        #1;
        check("wait_if_valid1", if_valid, 1);
        exp_q.push_back(32'h4);
        step();
        check("wait_next_addr", imem.imem_addr, 32'h8);
        exp_q.push_back(32'h8);
        step();

        // back-to-back random redirects drive the counter into saturation
        prev_tgt = 32'hC;
        for (int i = 0; i < 12; i++) begin
            tgt = $urandom() & 32'hFFFF_FFFE;
            drive_redirect(tgt | 32'($urandom_range(0, 1)));
            #1;
            check("sat_addr", imem.imem_addr, prev_tgt);
            check("sat_flush_id", flush_id, 1);
            step();
            bump_cnt();
            check("sat_cnt", redirect_cnt, m_cnt);
            prev_tgt = tgt;
        end
        clear_redirect();
        #1;
        check("sat_final_addr", imem.imem_addr, prev_tgt);
        check("sat_final_cnt", redirect_cnt, m_cnt);
        exp_q.push_back(prev_tgt);
        step();

        // reset asserted with a request outstanding
        imem.imem_ready = 1'b0;
        #1;
        step();
        check("mid_state", dbg_state, PCSEQ_WAIT);
        rst_n = 1'b0;
        #1;
        m_cnt = 0;
        check("mid_req", imem.imem_req, 0);
        check("mid_addr", imem.imem_addr, 0);
        check("mid_cnt", redirect_cnt, m_cnt);
        check("mid_state_rst", dbg_state, PCSEQ_BOOT);
        step();
        rst_n = 1'b1;
        imem.imem_ready = 1'b1;
        step();
        check("post_addr0", imem.imem_addr, 32'h0);
        check("post_if_valid", if_valid, 1);
        exp_q.push_back(32'h0);
        step();
        check("post_addr1", imem.imem_addr, 32'h4);
        exp_q.push_back(32'h4);
        step();

        rst_n = 1'b0;
        #1;
        step();
        check("sb_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_seq_ctrl.md
Name: pc_seq_ctrl

Overview:
Fetch-PC sequencer and pipeline-redirect controller for the 5-stage core. It owns the architectural fetch PC and drives the instruction-memory request handshake. It consumes the EX-stage branch decision (PCSel plus target) and the load-use hazard signal, and issues the IF/ID and ID/EX flushes and stalls. It sits between the branch control logic in EX and the IF stage / instruction memory port.

Parameters:
XLEN, 32, PC/target width.
RESET_PC, 32'h0000_0000, first fetch address after reset.
CNT_W, 32, width of the redirect performance counter.

Ports:
clk  in  1  core clock, rising edge.
rst_n  in  1  reset; asynchronous assert, active-low.
ex_valid  in  1  EX stage holds a live instruction.
pcsel_ex  in  `WIDTH_PCSEL  EX branch decision; `PCSEL_JUMP = redirect, `PCSEL_PC4 = sequential.
jump_target_ex  in  XLEN  EX-computed branch/jump target.
load_use_hz  in  1  ID needs to stall one cycle (load-use).
imem_req  out  1  fetch request valid.
imem_addr  out  XLEN  fetch address (= current PC).
imem_ready  in  1  memory accepts request this cycle.
if_valid  out  1  instruction returned this cycle is to be latched into IF/ID.
id_stall  out  1  hold IF/ID register.
flush_id  out  1  zero IF/ID (insert bubble).
flush_ex  out  1  zero ID/EX (insert bubble).
redirect_cnt  out  CNT_W  count of accepted redirects, saturating.

Behaviour:
- Reset (rst_n low, async): pc=RESET_PC, state=BOOT, pend_valid=0, redirect_cnt=0. imem_req=0, if_valid=0, id_stall=0, flush_id=0, flush_ex=0.
- States:
  - BOOT: one cycle after reset release, no request; then FETCH.
  - FETCH: imem_req=1, imem_addr=pc.
  - WAIT: request outstanding, imem_ready low.
  - DROP: one fetch accepted after a pending redirect is discarded.
- Handshake rules:
  - Transfer occurs when imem_req && imem_ready.
  - imem_addr must stay constant while imem_req && !imem_ready.
  - FETCH with !imem_ready goes to WAIT; WAIT with imem_ready goes to FETCH.
- Sequential advance: on a transfer with no redirect and no stall, if_valid=1 and pc<=pc+4. The add is modulo 2^XLEN (0xFFFF_FFFC wraps to 0).
- Redirect condition: ex_valid && pcsel_ex==`PCSEL_JUMP.
  - flush_id=1 and flush_ex=1 combinationally in that same cycle.
  - if_valid=0 that cycle.
  - redirect_cnt increments, saturating at all-ones.
  - Target is jump_target_ex with bit 0 forced to 0.
- Redirect in FETCH/BOOT, or in WAIT with imem_ready high: pc<=target next cycle; fetch of target issues the next cycle (one bubble).
- Redirect in WAIT with imem_ready low: the address must not change. Capture pend_pc=target, pend_valid=1. When the outstanding transfer completes, drop it (if_valid=0), then load pc<=pend_pc, clear pend_valid and return to FETCH.
- A second redirect while pend_valid=1 overwrites pend_pc (the younger branch was itself flushed, so this cannot occur legally; overwrite is the defined behaviour).
- Load-use stall (load_use_hz && no redirect):
  - id_stall=1, flush_ex=1 (bubble into EX), pc held.
  - if_valid=0; the fetched word is re-requested next cycle.
- Simultaneous redirect and load_use_hz: the redirect wins. id_stall=0, both flushes asserted.
- Latency: redirect decision to target on imem_addr is 1 cycle, or transfer-complete + 1 when pending.
- Reset mid-WAIT: all state is cleared asynchronously and the outstanding request is abandoned (the memory side is reset by the same rst_n).

Decomposition:
- Shared param header: `WIDTH_PCSEL, `PCSEL_JUMP, `PCSEL_PC4 (already present); add state encodings PCSEQ_BOOT/FETCH/WAIT/DROP and `RESET_PC default.
- One natural sub-module, sat_counter (width-parameterised saturating incrementer), reusable for other perf counters.

Test Plan:
- Reset release, imem_ready=1 constant -> imem_addr 0x0, 0x4, 0x8 on consecutive cycles after BOOT; if_valid=1 from first transfer.
- Taken branch: ex_valid=1, pcsel_ex=JUMP, target 0x0000_0101 at pc=0x10 -> flush_id=flush_ex=1 same cycle; next imem_addr=0x0000_0100; redirect_cnt=1.
- Redirect while imem_ready=0 at pc=0x20, target 0x80, ready high 2 cycles later -> imem_addr stays 0x20 throughout; that transfer has if_valid=0; next addr=0x80.
- load_use_hz=1 for one cycle at pc=0x40 -> id_stall=1, flush_ex=1, imem_addr 0x40 repeated, then 0x44.
- load_use_hz=1 and redirect same cycle (target 0x200) -> id_stall=0, flushes=1, next addr 0x200.
- pc=0xFFFF_FFFC sequential fetch -> next 0x0; redirect_cnt preset near max with further redirects -> holds at 0xFFFF_FFFF.
